// File: rtl/anim_pkg.sv
// Shared types and constants for the sprite/background/item animators.
// No logic of its own; imported by the tick divider and the sequencer.
// No flow control.
package anim_pkg;

  // Sequencer playback states.
  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    PAUSED = 2'd1,
    DONE   = 2'd2
  } anim_state_e;

  // Well-known animation set numbers for the character sprites.
  localparam int unsigned MODE_STATIC = 0;
  localparam int unsigned MODE_RWALK  = 1;
  localparam int unsigned MODE_LWALK  = 2;
  localparam int unsigned MODE_JUMP   = 3;

  // Base tick period in clk cycles.
  localparam int unsigned DEFAULT_TICK_DIV = 6000000;

  // Bit width able to index n items; never below 1 so ports stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/anim_tick_div.sv
// Free-running divider: one-cycle tick_o every DIV clk cycles.
// tick_o is combinational from the count register (asserted while count==DIV-1).
// No flow control; never stalls.
module anim_tick_div
  import anim_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = idx_w(DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  // Next count: wrap to zero on the terminal value.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sprite_anim_seq.sv
// Sprite animation sequencer: steps frames per mode, selects the frame ROM pixel.
// frame/rom_sel update on the decision edge; vga_pix follows rom_sel by two cycles.
// No flow control; pause freezes progression, the tick divider keeps running.
module sprite_anim_seq
  import anim_pkg::*;
#(
  parameter int unsigned       PIX_W        = 12,
  parameter int unsigned       FRAMES       = 4,
  parameter int unsigned       MODES        = 4,
  parameter int unsigned       TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int unsigned       HOLD_TICKS   = 1,
  parameter logic [MODES-1:0]  ONESHOT_MASK = 4'b1000,
  // Mode input width; may be widened by an integrator, out-of-range requests are ignored.
  parameter int unsigned       MODE_W       = idx_w(MODES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [MODE_W-1:0]               mode_i,
  input  logic                            restart_i,
  input  logic                            pause_i,
  input  logic [MODES*FRAMES*PIX_W-1:0]   rom_pix_bus_i,
  output logic [idx_w(MODES*FRAMES)-1:0]  rom_sel_o,
  output logic [idx_w(FRAMES)-1:0]        frame_o,
  output logic [PIX_W-1:0]                vga_pix_o,
  output logic                            wrap_o,
  output logic                            done_o
);

  localparam int CM_W  = idx_w(MODES);
  localparam int FR_W  = idx_w(FRAMES);
  localparam int HD_W  = idx_w(HOLD_TICKS);
  localparam int SEL_W = idx_w(MODES * FRAMES);

  logic                tick;
  anim_state_e         state_q,    state_d;
  logic [CM_W-1:0]     cur_mode_q, cur_mode_d;
  logic [FR_W-1:0]     frame_q,    frame_d;
  logic [HD_W-1:0]     hold_q,     hold_d;
  logic                done_q,     done_d;
  logic                wrap_q,     wrap_d;
  logic [SEL_W-1:0]    rom_sel_q,  rom_sel_d;
  // rom_sel as seen by the block ROMs one cycle ago, i.e. aligned to their data.
  logic [SEL_W-1:0]    sel_d1_q;
  logic [PIX_W-1:0]    vga_pix_q;

  logic                mode_chg;
  logic                oneshot;
  logic                last_frame;
  logic                hold_last;

  anim_tick_div #(
    .DIV (TICK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  assign mode_chg   = (int'(mode_i) < int'(MODES)) && (int'(mode_i) != int'(cur_mode_q));
  assign oneshot    = ONESHOT_MASK[cur_mode_q];
  assign last_frame = (int'(frame_q) == int'(FRAMES) - 1);
  assign hold_last  = (int'(hold_q) == int'(HOLD_TICKS) - 1);

  // Next state: mode change beats restart, restart beats frame advance.
  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    frame_d    = frame_q;
    hold_d     = hold_q;
    done_d     = done_q;
    wrap_d     = 1'b0;

    if (mode_chg) begin
      cur_mode_d = CM_W'(mode_i);
      frame_d    = '0;
      hold_d     = '0;
      done_d     = 1'b0;
      state_d    = pause_i ? PAUSED : PLAY;
    end else if (restart_i) begin
      frame_d    = '0;
      hold_d     = '0;
      done_d     = 1'b0;
      state_d    = pause_i ? PAUSED : PLAY;
    end else begin
      case (state_q)
        PLAY: begin
          if (pause_i) begin
            state_d = PAUSED;
          end else if (tick) begin
            if (hold_last) begin
              hold_d = '0;
              if (last_frame) begin
                // One-shot modes never sit here in PLAY; guard keeps them parked anyway.
                if (!oneshot) begin
                  frame_d = '0;
                  wrap_d  = 1'b1;
                end
              end else begin
                frame_d = frame_q + FR_W'(1);
                if (oneshot && (int'(frame_q) == int'(FRAMES) - 2)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                end
              end
            end else begin
              hold_d = hold_q + HD_W'(1);
            end
          end
        end
        PAUSED: begin
          if (!pause_i) begin
            state_d = PLAY;
          end
        end
        DONE: begin
          // Only a mode change or restart (handled above) leaves DONE.
        end
        default: begin
          state_d = PLAY;
        end
      endcase
    end

    rom_sel_d = SEL_W'(int'(cur_mode_d) * int'(FRAMES) + int'(frame_d));
  end

  // Sequencer registers and the two-stage pixel path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PLAY;
      cur_mode_q <= '0;
      frame_q    <= '0;
      hold_q     <= '0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      rom_sel_q  <= '0;
      sel_d1_q   <= '0;
      vga_pix_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      frame_q    <= frame_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
      rom_sel_q  <= rom_sel_d;
      sel_d1_q   <= rom_sel_q;
      vga_pix_q  <= rom_pix_bus_i[int'(sel_d1_q)*int'(PIX_W) +: PIX_W];
    end
  end

  assign rom_sel_o = rom_sel_q;
  assign frame_o   = frame_q;
  assign vga_pix_o = vga_pix_q;
  assign wrap_o    = wrap_q;
  assign done_o    = done_q;

endmodule
